// File: rtl/l1_bus_arbiter_pkg.sv
// rtl/l1_bus_arbiter_pkg.sv - shared types and geometry for the L1 line-port arbiter
package l1_bus_arbiter_pkg;

  localparam int BLK_LEN_DEF = 58;
  localparam int LINE_DEF    = 512;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } arb_state_t;

  // Which requester owns the transaction in flight, and what it asked for
  typedef enum logic [1:0] {
    OWN_I  = 2'd0,
    OWN_DR = 2'd1,
    OWN_DW = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/l1_bus_arbiter_if.sv
// rtl/l1_bus_arbiter_if.sv - cache-side and memory-side line port bundle
interface l1_bus_arbiter_if
  import l1_bus_arbiter_pkg::*;
#(
  parameter int BLK_LEN = BLK_LEN_DEF,
  parameter int LINE    = LINE_DEF
);
  logic [BLK_LEN-1:0] i_addr;
  logic               i_rd;
  logic [LINE-1:0]    i_data;
  logic               i_dv;
  logic [BLK_LEN-1:0] d_addr;
  logic               d_rd;
  logic               d_wr;
  logic [LINE-1:0]    d_wdata;
  logic [LINE-1:0]    d_data;
  logic               d_dv;
  logic [BLK_LEN-1:0] m_addr;
  logic               m_rd;
  logic               m_wr;
  logic [LINE-1:0]    m_wdata;
  logic [LINE-1:0]    m_rdata;
  logic               m_ack;

  // Arbiter view
  modport slave (
    input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    output i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata
  );

  // Caches plus memory, i.e. everything around the arbiter
  modport master (
    output i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    input  i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata
  );
endinterface

// File: rtl/l1_bus_arbiter_rr2.sv
// rtl/l1_bus_arbiter_rr2.sv - two-way round-robin picker with last-grant memory
module arb_rr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);
  // 1 = D side (req[1]) was granted last; reset favours I on first contention
  logic last_d_q;

  // Lone requester wins outright; on contention the side not granted last time wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_d_q ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of every actual grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d_q <= 1'b1;
    end else if (grant_en && (req != 2'b00)) begin
      last_d_q <= gnt[1];
    end
  end
endmodule

// File: rtl/l1_bus_arbiter.sv
// rtl/l1_bus_arbiter.sv - shares one memory line port between L1 I and D caches
module l1_bus_arbiter
  import l1_bus_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  l1_bus_arbiter_if.slave  bus
);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q;
  logic [1:0] gnt;
  logic       grant_en;

  assign grant_en = (state_q == S_IDLE);

  arb_rr2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({bus.d_rd | bus.d_wr, bus.i_rd}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  // Next-state: one transaction at a time, ADDR waits out the requester's address lag
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (gnt != 2'b00) state_d = S_ADDR;
      S_ADDR: state_d = S_WAIT;
      S_WAIT: if (bus.m_ack) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Record owner and operation at grant; a pending D write-back beats a D fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_I;
    end else if (grant_en && (gnt != 2'b00)) begin
      if (gnt[0])         owner_q <= OWN_I;
      else if (bus.d_wr)  owner_q <= OWN_DW;
      else                owner_q <= OWN_DR;
    end
  end

  // Memory strobes, address/write data latching and fill-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_rd    <= 1'b0;
      bus.m_wr    <= 1'b0;
      bus.i_data  <= '0;
      bus.d_data  <= '0;
    end else begin
      case (state_q)
        S_ADDR: begin
          bus.m_addr <= (owner_q == OWN_I) ? bus.i_addr : bus.d_addr;
          if (owner_q == OWN_DW) bus.m_wdata <= bus.d_wdata;
          bus.m_rd <= (owner_q != OWN_DW);
          bus.m_wr <= (owner_q == OWN_DW);
        end
        S_WAIT: begin
          if (bus.m_ack) begin
            bus.m_rd <= 1'b0;
            bus.m_wr <= 1'b0;
            if (owner_q == OWN_I)  bus.i_data <= bus.m_rdata;
            if (owner_q == OWN_DR) bus.d_data <= bus.m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_dv = (state_q == S_RESP) && (owner_q == OWN_I);
  assign bus.d_dv = (state_q == S_RESP) && (owner_q != OWN_I);
endmodule

// File: tb/tb_l1_bus_arbiter.sv
// tb/tb_l1_bus_arbiter.sv - directed self-checking bench for l1_bus_arbiter
module tb_l1_bus_arbiter;
  import l1_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_bus_arbiter_if bus ();

  l1_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [511:0] DAT_A = {16{32'hA5A5_0001}};
  localparam logic [511:0] DAT_B = {16{32'hB0B0_0002}};
  localparam logic [511:0] DAT_C = {16{32'hC3C3_0003}};
  localparam logic [511:0] DAT_E = {16{32'hE1E1_0004}};
  localparam logic [511:0] DAT_G = {16{32'h6767_0005}};
  localparam logic [511:0] DAT_W = {16{32'hDEAD_BEEF}};
  localparam logic [511:0] DAT_J = {16{32'h1234_5678}};
  localparam logic [511:0] DAT_V = {16{32'h0BAD_F00D}};
  localparam logic [511:0] DAT_H = {16{32'h4848_0006}};
  localparam logic [511:0] DAT_K = {16{32'h7171_0007}};

  int n_checks = 0;
  int n_pass = 0;
  int i_dv_cnt = 0;
  int d_dv_cnt = 0;
  int overlap_cnt = 0;
  int mwr_cnt = 0;
  int mrd_cnt = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event monitor sampled mid-cycle
  always @(negedge clk) begin
    if (bus.i_dv) i_dv_cnt++;
    if (bus.d_dv) d_dv_cnt++;
    if ((bus.m_rd && bus.m_wr) || (bus.i_dv && bus.d_dv)) overlap_cnt++;
    if (bus.m_wr) mwr_cnt++;
    if (bus.m_rd) mrd_cnt++;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int i0, d0, r0;

  initial begin
    bus.i_addr = '0; bus.i_rd = 0; bus.d_addr = '0; bus.d_rd = 0; bus.d_wr = 0;
    bus.d_wdata = '0; bus.m_rdata = '0; bus.m_ack = 0;
    #1;

    // 1 reset held two cycles with i_rd high
    bus.i_rd = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_m_rd", bus.m_rd, 0);
      chk("rst_i_dv", bus.i_dv, 0);
      chk("rst_state", dut.state_q, S_IDLE);
    end
    chk("rst_m_addr", bus.m_addr, 0);
    bus.i_rd = 0;
    rst_n = 1;
    tick();

    // 2 lone I fill: cycle 0 now
    d0 = d_dv_cnt; i0 = i_dv_cnt;
    bus.i_rd = 1;
    tick();                                     // cycle 1
    bus.i_addr = 58'h12;
    chk("t2_c1_m_rd", bus.m_rd, 0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) begin bus.m_ack = 1; bus.m_rdata = DAT_A; end
      chk("t2_m_rd", bus.m_rd, 1);
      chk("t2_m_addr", bus.m_addr, 58'h12);
      chk("t2_i_dv_low", bus.i_dv, 0);
    end
    tick();                                     // cycle 6
    bus.m_ack = 0; bus.i_rd = 0;
    chk("t2_i_dv", bus.i_dv, 1);
    chk("t2_i_data", bus.i_data, DAT_A);
    chk("t2_m_rd_drop", bus.m_rd, 0);
    tick();                                     // cycle 7
    chk("t2_i_dv_once", i_dv_cnt - i0, 1);
    chk("t2_d_dv_none", d_dv_cnt - d0, 0);

    // 3 contention after reset: I first, then D, next double goes to I
    do_reset();                                 // cycle 0
    bus.i_rd = 1; bus.d_rd = 1;
    tick();                                     // 1
    bus.i_addr = 58'h100; bus.d_addr = 58'h200;
    tick();                                     // 2
    chk("t3_first_addr", bus.m_addr, 58'h100);
    chk("t3_first_rd", bus.m_rd, 1);
    tick();                                     // 3
    bus.m_ack = 1; bus.m_rdata = DAT_B;
    tick();                                     // 4
    bus.m_ack = 0;
    chk("t3_i_dv", bus.i_dv, 1);
    chk("t3_d_dv0", bus.d_dv, 0);
    chk("t3_i_data", bus.i_data, DAT_B);
    bus.i_rd = 0;
    tick();                                     // 5
    chk("t3_idle", dut.state_q, S_IDLE);
    tick();                                     // 6
    chk("t3_d_granted", dut.state_q, S_ADDR);
    tick();                                     // 7
    chk("t3_second_addr", bus.m_addr, 58'h200);
    bus.m_ack = 1; bus.m_rdata = DAT_C;
    tick();                                     // 8
    bus.m_ack = 0;
    chk("t3_d_dv", bus.d_dv, 1);
    chk("t3_d_data", bus.d_data, DAT_C);
    chk("t3_i_data_kept", bus.i_data, DAT_B);
    bus.d_rd = 0;
    tick();                                     // 9
    bus.i_rd = 1; bus.d_rd = 1;
    tick();
    bus.i_addr = 58'h300; bus.d_addr = 58'h400;
    tick();                                     // 11
    chk("t3_rr_back_to_i", bus.m_addr, 58'h300);
    bus.m_ack = 1; bus.m_rdata = DAT_E;
    tick();                                     // 12
    bus.m_ack = 0; bus.i_rd = 0;
    chk("t3_i_data2", bus.i_data, DAT_E);
    tick(); tick(); tick();                     // 15
    chk("t3_d_addr2", bus.m_addr, 58'h400);
    bus.m_ack = 1; bus.m_rdata = DAT_G;
    tick();                                     // 16
    bus.m_ack = 0; bus.d_rd = 0;
    chk("t3_d_data2", bus.d_data, DAT_G);
    tick();

    // 4 write-back
    d0 = d_dv_cnt; r0 = mrd_cnt;
    bus.d_wr = 1;
    tick();                                     // 1
    bus.d_addr = 58'h40; bus.d_wdata = DAT_W;
    tick();                                     // 2
    chk("t4_m_wr", bus.m_wr, 1);
    chk("t4_m_wdata", bus.m_wdata, DAT_W);
    chk("t4_m_addr", bus.m_addr, 58'h40);
    tick();                                     // 3
    chk("t4_m_wr_hold", bus.m_wr, 1);
    bus.m_ack = 1; bus.m_rdata = DAT_J;
    tick();                                     // 4
    bus.m_ack = 0; bus.d_wr = 0;
    chk("t4_d_dv", bus.d_dv, 1);
    chk("t4_d_data_kept", bus.d_data, DAT_G);
    chk("t4_m_wr_drop", bus.m_wr, 0);
    tick();
    chk("t4_d_dv_once", d_dv_cnt - d0, 1);
    chk("t4_no_m_rd", mrd_cnt - r0, 0);

    // 5 d_rd and d_wr together: write first, then read
    d0 = d_dv_cnt; r0 = mwr_cnt;
    bus.d_rd = 1; bus.d_wr = 1;
    tick();                                     // 1
    bus.d_addr = 58'h50; bus.d_wdata = DAT_V;
    tick();                                     // 2
    chk("t5_wr_first", bus.m_wr, 1);
    chk("t5_wr_noread", bus.m_rd, 0);
    chk("t5_wr_addr", bus.m_addr, 58'h50);
    bus.m_ack = 1;
    tick();                                     // 3
    bus.m_ack = 0; bus.d_wr = 0;
    chk("t5_wr_dv", bus.d_dv, 1);
    tick();                                     // 4
    bus.d_addr = 58'h60;
    tick(); tick();                             // 6
    chk("t5_rd_second", bus.m_rd, 1);
    chk("t5_rd_addr", bus.m_addr, 58'h60);
    bus.m_ack = 1; bus.m_rdata = DAT_H;
    tick();                                     // 7
    bus.m_ack = 0; bus.d_rd = 0;
    chk("t5_rd_data", bus.d_data, DAT_H);
    tick(); tick();
    chk("t5_two_dv", d_dv_cnt - d0, 2);
    chk("t5_wr_cycles", mwr_cnt - r0, 1);

    // 6 reset during S_WAIT, held i_rd served afterwards; stray m_ack ignored
    i0 = i_dv_cnt;
    bus.i_rd = 1;
    tick();                                     // 1
    bus.i_addr = 58'h70;
    tick();                                     // 2
    chk("t6_wait_rd", bus.m_rd, 1);
    tick();                                     // 3
    rst_n = 0;
    tick();                                     // 4
    rst_n = 1;
    chk("t6_rd_dropped", bus.m_rd, 0);
    chk("t6_no_dv", bus.i_dv, 0);
    tick();                                     // 5 (S_ADDR)
    bus.m_ack = 1; bus.m_rdata = DAT_K;
    tick();                                     // 6
    bus.m_ack = 0;
    chk("t6_rd_again", bus.m_rd, 1);
    chk("t6_addr", bus.m_addr, 58'h70);
    chk("t6_stray_ack", bus.i_dv, 0);
    bus.m_ack = 1; bus.m_rdata = DAT_A;
    tick();                                     // 7
    bus.m_ack = 0; bus.i_rd = 0;
    chk("t6_i_data", bus.i_data, DAT_A);
    tick();
    chk("t6_one_dv", i_dv_cnt - i0, 1);

    chk("no_overlap", overlap_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
